// File: rtl/cum_ctrl_pkg.sv
// Shared types and constants for the cumulative-sum controller.
`timescale 1ns/1ps
package cum_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    INIT_I   = 4'd1,
    INIT_SUM = 4'd2,
    INIT_ONE = 4'd3,
    CHECK    = 4'd4,
    ADD      = 4'd5,
    INC      = 4'd6,
    OUT      = 4'd7,
    DONE     = 4'd8
  } state_t;

  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] R_ZERO = 3'd0;
  localparam logic [ADDR_W-1:0] R_I    = 3'd1;
  localparam logic [ADDR_W-1:0] R_SUM  = 3'd2;
  localparam logic [ADDR_W-1:0] R_ONE  = 3'd3;

  localparam logic SEL_ADDER = 1'b0;
  localparam logic SEL_ONE   = 1'b1;

  // Control word driven onto the datapath each cycle.
  typedef struct packed {
    logic              sel;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [ADDR_W-1:0] wa;
    logic              we;
    logic              out_buf;
    logic              busy;
    logic              done;
  } ctrl_t;

  // Moore decode: control word that belongs to a given state.
  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c      = '0;
    c.busy = (s != IDLE);
    case (s)
      INIT_I: begin
        c.sel = SEL_ONE;
        c.wa  = R_I;
        c.we  = 1'b1;
      end
      INIT_SUM: begin
        c.sel = SEL_ADDER;
        c.ra1 = R_ZERO;
        c.ra2 = R_ZERO;
        c.wa  = R_SUM;
        c.we  = 1'b1;
      end
      INIT_ONE: begin
        c.sel = SEL_ONE;
        c.wa  = R_ONE;
        c.we  = 1'b1;
      end
      CHECK: begin
        c.ra1 = R_I;
      end
      ADD: begin
        c.sel = SEL_ADDER;
        c.ra1 = R_SUM;
        c.ra2 = R_I;
        c.wa  = R_SUM;
        c.we  = 1'b1;
      end
      INC: begin
        c.sel = SEL_ADDER;
        c.ra1 = R_I;
        c.ra2 = R_ONE;
        c.wa  = R_I;
        c.we  = 1'b1;
      end
      OUT: begin
        c.ra1     = R_SUM;
        c.out_buf = 1'b1;
      end
      DONE: begin
        c.done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cum_adder_ctrl.sv
// Sequences the RF/adder datapath to accumulate 1+2+...+N, with start/busy/done
// handshake and an iteration watchdog.
`timescale 1ns/1ps
module cum_adder_ctrl
  import cum_ctrl_pkg::*;
#(
  parameter int unsigned MAX_ITER = 15,
  parameter int unsigned ITER_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              iLe10,
  output logic              RFSrcMuxSel,
  output logic [2:0]        readAddr1,
  output logic [2:0]        readAddr2,
  output logic [2:0]        writeAddr,
  output logic              writeEn,
  output logic              outBuf,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_cnt
);

  state_t              r_state;
  state_t              w_next_state;
  ctrl_t               r_ctrl;
  ctrl_t               w_ctrl_next;
  logic [ITER_W-1:0]   r_iter_cnt;
  logic                r_err;
  logic                w_start_run;
  logic                w_wd_trip;

  // Next-state selection; control word is decoded from the upcoming state so it
  // can be registered yet still track the state register cycle for cycle.
  always_comb begin
    w_next_state = r_state;
    w_start_run  = 1'b0;
    w_wd_trip    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = INIT_I;
          w_start_run  = 1'b1;
        end
      end
      INIT_I:   w_next_state = INIT_SUM;
      INIT_SUM: w_next_state = INIT_ONE;
      INIT_ONE: w_next_state = CHECK;
      CHECK: begin
        if (!iLe10) begin
          w_next_state = OUT;
        end else if (r_iter_cnt == ITER_W'(MAX_ITER)) begin
          w_next_state = OUT;
          w_wd_trip    = 1'b1;
        end else begin
          w_next_state = ADD;
        end
      end
      ADD:     w_next_state = INC;
      INC:     w_next_state = CHECK;
      OUT:     w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    w_ctrl_next = ctrl_decode(w_next_state);
  end

  // State and registered control word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next_state;
      r_ctrl  <= w_ctrl_next;
    end
  end

  // Iteration counter (saturating) and sticky watchdog flag, both cleared on an
  // accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_iter_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_start_run) begin
      r_iter_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == INC && r_iter_cnt != '1) begin
        r_iter_cnt <= r_iter_cnt + ITER_W'(1);
      end
      if (w_wd_trip) begin
        r_err <= 1'b1;
      end
    end
  end

  assign RFSrcMuxSel = r_ctrl.sel;
  assign readAddr1   = r_ctrl.ra1;
  assign readAddr2   = r_ctrl.ra2;
  assign writeAddr   = r_ctrl.wa;
  assign writeEn     = r_ctrl.we;
  assign outBuf      = r_ctrl.out_buf;
  assign busy        = r_ctrl.busy;
  assign done        = r_ctrl.done;
  assign err         = r_err;
  assign iter_cnt    = r_iter_cnt;

endmodule

// File: tb/tb_cum_adder_ctrl.sv
// Bench for cum_adder_ctrl: behavioural RF/adder datapath plus a cycle
// schedule reference derived from the sequence timing.
`timescale 1ns/1ps
module tb_cum_adder_ctrl;

  localparam int unsigned MAX_ITER = 15;
  localparam int unsigned ITER_W   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              iLe10;
  logic              RFSrcMuxSel;
  logic [2:0]        readAddr1;
  logic [2:0]        readAddr2;
  logic [2:0]        writeAddr;
  logic              writeEn;
  logic              outBuf;
  logic              busy;
  logic              done;
  logic              err;
  logic [ITER_W-1:0] iter_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rf [0:7];
  logic [7:0] out_port;
  logic       force_le;
  logic [13:0] w_obs;

  always #5 clk = ~clk;

  cum_adder_ctrl #(.MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .iLe10       (iLe10),
    .RFSrcMuxSel (RFSrcMuxSel),
    .readAddr1   (readAddr1),
    .readAddr2   (readAddr2),
    .writeAddr   (writeAddr),
    .writeEn     (writeEn),
    .outBuf      (outBuf),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .iter_cnt    (iter_cnt)
  );

  assign w_obs = {RFSrcMuxSel, readAddr1, readAddr2, writeAddr, writeEn, outBuf, busy, done};

  // Datapath model: RF with hardwired R0, 8-bit adder, comparator, output reg.
  assign iLe10 = force_le | (rf[readAddr1] <= 8'd10);

  always @(posedge clk) begin
    if (writeEn && writeAddr != 3'd0)
      rf[writeAddr] <= RFSrcMuxSel ? 8'd1 : 8'(rf[readAddr1] + rf[readAddr2]);
    if (outBuf)
      out_port <= rf[readAddr1];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic scramble_rf();
    rf[0] = 8'd0;
    for (int i = 1; i < 8; i++) rf[i] = 8'($urandom);
  endtask

  // Expected sum: 1+2+...+L, 8-bit wrap.
  function automatic logic [7:0] ref_sum(input int l);
    int s;
    s = 0;
    for (int i = 1; i <= l; i++) s += i;
    return 8'(s % 256);
  endfunction

  // Number of loop iterations: count while i<=10, or the watchdog limit if forced.
  function automatic int ref_loops(input bit forced);
    int n;
    int i;
    if (forced) return int'(MAX_ITER);
    n = 0;
    i = 1;
    while (i <= 10) begin
      n++;
      i++;
    end
    return n;
  endfunction

  // Phase of cycle c of a run with l iterations:
  // 0 INIT_I, 1 INIT_SUM, 2 INIT_ONE, 3 CHECK, 4 ADD, 5 INC, 6 OUT, 7 DONE.
  function automatic int phase_of(input int c, input int l);
    if (c <= 3)         return c - 1;
    if (c <= 3 + 3 * l) return 3 + (c - 4) % 3;
    if (c == 4 + 3 * l) return 3;
    if (c == 5 + 3 * l) return 6;
    return 7;
  endfunction

  // Expected {sel, rA1, rA2, wA, we, outBuf, busy, done} for a phase.
  function automatic logic [13:0] exp_ctrl(input int ph);
    logic [13:0] r;
    case (ph)
      0:       r = {1'b1, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0};
      1:       r = {1'b0, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
      2:       r = {1'b1, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0};
      3:       r = {1'b0, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      4:       r = {1'b0, 3'd2, 3'd1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
      5:       r = {1'b0, 3'd1, 3'd3, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0};
      6:       r = {1'b0, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0};
      7:       r = {1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1};
      default: r = '0;
    endcase
    return r;
  endfunction

  // One run; caller has start=1 before the sampling edge. Extra start pulses
  // at cycles p0..p2; abort_c>0 asserts reset asynchronously in that cycle.
  task automatic run(input bit wd, input bit hold, input int p0, input int p1,
                     input int p2, input int abort_c);
    int  l;
    int  it;
    bit  seen;
    l    = ref_loops(wd);
    seen = 1'b0;
    for (int c = 1; c <= 120 && !seen; c++) begin
      @(posedge clk);
      if (c == abort_c) begin
        #2 reset = 1'b1;
        #1;
        chk("abort_outputs", 32'(w_obs), 32'd0);
        chk("abort_iter", 32'(iter_cnt), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      @(negedge clk);
      start = hold || c == p0 || c == p1 || c == p2;
      it = (c <= 4) ? 0 : (c - 4) / 3;
      if (it > l) it = l;
      chk("ctrl", 32'(w_obs), 32'(exp_ctrl(phase_of(c, l))));
      chk("iter_cnt", 32'(iter_cnt), 32'(it));
      chk("err", 32'(err), 32'(wd && c >= 5 + 3 * l));
      if (done) begin
        seen = 1'b1;
        chk("done_cycle", 32'(c), 32'(6 + 3 * l));
        chk("out_port", 32'(out_port), 32'(ref_sum(l)));
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // One cycle that must be IDLE; err must hold its sticky value.
  task automatic idle_check(input bit exp_err);
    @(posedge clk);
    @(negedge clk);
    chk("idle_ctrl", 32'(w_obs), 32'd0);
    chk("idle_err", 32'(err), 32'(exp_err));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    force_le = 1'b0;
    out_port = 8'd0;
    scramble_rf();
    @(negedge clk);
    @(negedge clk);
    chk("reset_ctrl", 32'(w_obs), 32'd0);
    chk("reset_iter", 32'(iter_cnt), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    reset = 1'b0;
    idle_check(1'b0);

    // Basic run.
    start = 1'b1;
    run(1'b0, 1'b0, 0, 0, 0, 0);
    idle_check(1'b0);

    // start pulses while busy are ignored.
    start = 1'b1;
    run(1'b0, 1'b0, 5, 20, 30, 0);
    idle_check(1'b0);

    // start held high: back-to-back runs with one IDLE cycle between.
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run(1'b0, 1'b1, 0, 0, 0, 0);
      if (k == 2) start = 1'b0;
      idle_check(1'b0);
    end

    // Asynchronous reset in the middle of ADD, then a clean run over stale RF.
    start = 1'b1;
    run(1'b0, 1'b0, 0, 0, 0, 20);
    chk("post_abort_ctrl", 32'(w_obs), 32'd0);
    scramble_rf();
    start = 1'b1;
    run(1'b0, 1'b0, 0, 0, 0, 0);
    idle_check(1'b0);

    // Watchdog: comparator stuck true.
    force_le = 1'b1;
    start    = 1'b1;
    run(1'b1, 1'b0, 0, 0, 0, 0);
    idle_check(1'b1);
    idle_check(1'b1);
    force_le = 1'b0;
    start    = 1'b1;
    run(1'b0, 1'b0, 0, 0, 0, 0);
    idle_check(1'b0);

    // Randomised: stale RF, random busy-time start pulses, random idle gaps,
    // occasional watchdog run.
    for (int k = 0; k < 6; k++) begin
      bit wd;
      int gap;
      wd  = ($urandom_range(0, 3) == 0);
      gap = int'($urandom_range(0, 4));
      scramble_rf();
      for (int g = 0; g < gap; g++) idle_check(1'b0);
      force_le = wd;
      start    = 1'b1;
      run(wd, 1'b0, int'($urandom_range(2, 40)), int'($urandom_range(2, 40)),
          int'($urandom_range(2, 40)), 0);
      force_le = 1'b0;
      idle_check(wd);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("rnd_restart_err_clear", 32'(err), 32'd0);
      chk("rnd_restart_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cum_adder_ctrl.md
Name: cum_adder_ctrl

Overview:
FSM controller that sequences the 8-bit register-file/adder datapath to compute the cumulative sum 1+2+...+N, with N=10 fixed by the datapath's i<=10 comparator. It drives the RF source mux select, RF read/write addresses, write enable and output-register load, and consumes the datapath's iLe10 status. It provides a start/busy/done handshake and an iteration watchdog. The system top instantiates it beside the datapath.

Parameters:
MAX_ITER, 15, watchdog limit on loop iterations; must be >= 10 and < 2**ITER_W.
ITER_W, 4, width of iter_cnt.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  level; sampled only in IDLE
iLe10  input  1  datapath status, RF read port 1 value <= 10 (combinational from readAddr1)
RFSrcMuxSel  output  1  0 = adder result, 1 = constant 1
readAddr1  output  3  RF read port 1 address
readAddr2  output  3  RF read port 2 address
writeAddr  output  3  RF write address
writeEn  output  1  RF write enable
outBuf  output  1  output-register load enable
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse in DONE
err  output  1  sticky watchdog flag
iter_cnt  output  ITER_W  completed loop iterations

Behaviour:
- RF map: R0 = hardwired 0, R1 = i, R2 = sum, R3 = constant 1. RF writes land on the clock edge; reads are combinational.
- Moore FSM. All control outputs decode from state only. Outputs not listed for a state are 0.
- IDLE: start=1 -> INIT_I, clears iter_cnt and err. Otherwise hold.
- INIT_I: sel=1, wA=1, we=1 (R1<=1). -> INIT_SUM.
- INIT_SUM: sel=0, rA1=0, rA2=0, wA=2, we=1 (R2<=0+0). -> INIT_ONE.
- INIT_ONE: sel=1, wA=3, we=1 (R3<=1). -> CHECK.
- CHECK: rA1=1, no write.
  - If iLe10=0 -> OUT.
  - If iLe10=1 and iter_cnt==MAX_ITER -> OUT, set err.
  - Otherwise -> ADD.
- ADD: sel=0, rA1=2, rA2=1, wA=2, we=1 (R2<=R2+R1). -> INC.
- INC: sel=0, rA1=1, rA2=3, wA=1, we=1 (R1<=R1+R3). iter_cnt += 1 (saturates at 2**ITER_W-1). -> CHECK.
- OUT: rA1=2, outBuf=1. Datapath outPort takes R2 at the end of this cycle. -> DONE.
- DONE: done=1. -> IDLE unconditionally. start still high then re-runs on the next IDLE cycle.
- Latency: start sampled at edge 0.
  - INIT states occupy cycles 1-3.
  - Ten CHECK/ADD/INC loops occupy cycles 4-33.
  - Final CHECK is cycle 34, OUT is cycle 35.
  - DONE (done=1) is cycle 36; outPort=55 (0x37) from cycle 36 onward. iter_cnt=10 at done.
- start while busy: ignored, no effect on sequence.
- Reset (any time, including mid-run):
  - State -> IDLE; iter_cnt=0; err=0.
  - All outputs 0: addresses 0, writeEn=0, outBuf=0, busy=0, done=0.
  - RF contents are not reset. The INIT states re-initialise R1-R3 on every run, so stale values never affect results.
- Sum arithmetic is 8-bit modulo in the datapath. The controller does no arithmetic beyond iter_cnt.
- err holds until the next accepted start or reset.
- Illegal or unused state encodings -> IDLE.

Decomposition:
- Package cum_ctrl_pkg holds:
  - state_t enum: IDLE, INIT_I, INIT_SUM, INIT_ONE, CHECK, ADD, INC, OUT, DONE.
  - RF address constants: R_ZERO=0, R_I=1, R_SUM=2, R_ONE=3.
  - Mux constants: SEL_ADDER=0, SEL_ONE=1.
- Single module, no sub-module. Next-state logic, output decode and iter_cnt/err registers live in one file.

Test Plan:
- Integrated with datapath; reset, then start pulse -> busy at cycle 1, done pulse exactly at cycle 36, outPort=55, iter_cnt=10, err=0.
- start pulsed again at cycles 5, 20 and 30 during a run -> no change in state trace; done still at cycle 36 with 55.
- start held high continuously -> done every 37 cycles, outPort=55 each run, one-cycle IDLE between runs.
- Reset asserted asynchronously at cycle 20 (mid-ADD), RF holding stale values -> all outputs 0 immediately; new start -> 55 at done.
- Standalone, iLe10 forced to 1 -> after 15 iterations CHECK goes to OUT; err=1, iter_cnt=15, done pulses; err clears on next start.
- Standalone scoreboard of per-state outputs -> INIT_SUM drives rA1=rA2=0, wA=2, we=1, sel=0; INC drives rA1=1, rA2=3, wA=1; OUT drives rA1=2, outBuf=1 for exactly one cycle.
